// File: rtl/dm_bus_arb_pkg.sv
// Shared helpers for the dm bus arbiter slice.
// Index arithmetic lives here; sizing and the state enum stay local to each module.
package dm_bus_arb_pkg;

    localparam int unsigned MaxMasters = 8;

    // Increment an index modulo n without a divider.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dm_bus_arb_rr_sel.sv
// Round-robin selector: picks the first set request at or after ptr, wrapping to 0.
module dm_rr_sel
    import dm_bus_arb_pkg::*;
#(
    parameter int unsigned NrMasters = 2,
    parameter int unsigned IdxW      = $clog2(NrMasters)
) (
    input  logic [NrMasters-1:0] req,
    input  logic [IdxW-1:0]      ptr,
    output logic                 valid,
    output logic [IdxW-1:0]      index
);

    int unsigned pos;

    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            pos = (32'(ptr) + i) % NrMasters;
            if (!valid && req[pos]) begin
                valid = 1'b1;
                index = pos[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/dm_bus_arb.sv
// Round-robin arbiter funnelling NrMasters requesters onto one bus master port.
// Exactly one transaction is in flight: IDLE -> REQ (until grant) -> RESP (until response).
module dm_bus_arb
    import dm_bus_arb_pkg::*;
#(
    parameter int unsigned NrMasters = 2,
    parameter int unsigned BusWidth  = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrMasters-1:0]                  req_i,
    input  logic [NrMasters-1:0]                  we_i,
    input  logic [NrMasters-1:0][BusWidth-1:0]    add_i,
    input  logic [NrMasters-1:0][BusWidth-1:0]    wdata_i,
    input  logic [NrMasters-1:0][BusWidth/8-1:0]  be_i,
    output logic [NrMasters-1:0]                  gnt_o,
    output logic [NrMasters-1:0]                  r_valid_o,
    output logic [BusWidth-1:0]                   r_rdata_o,
    output logic                                  master_req_o,
    output logic [BusWidth-1:0]                   master_add_o,
    output logic                                  master_we_o,
    output logic [BusWidth-1:0]                   master_wdata_o,
    output logic [BusWidth/8-1:0]                 master_be_o,
    input  logic                                  master_gnt_i,
    input  logic                                  master_r_valid_i,
    input  logic [BusWidth-1:0]                   master_r_rdata_i
);

    localparam int unsigned IdxW = $clog2(NrMasters);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state, state_next;
    logic [IdxW-1:0] ptr, winner, sel_idx;
    logic            sel_valid;

    dm_rr_sel #(
        .NrMasters (NrMasters),
        .IdxW      (IdxW)
    ) u_rr_sel (
        .req   (req_i),
        .ptr   (ptr),
        .valid (sel_valid),
        .index (sel_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && sel_valid) begin
                winner <= sel_idx;
            end
            // Pointer only advances on completion, so an abandoned transaction leaves fairness untouched.
            if (state == RESP && master_r_valid_i) begin
                ptr <= IdxW'(wrap_inc(32'(winner), NrMasters));
            end
        end
    end

    always_comb begin
        state_next     = state;
        master_req_o   = 1'b0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        gnt_o          = '0;
        r_valid_o      = '0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                master_req_o   = 1'b1;
                master_add_o   = add_i[winner];
                master_we_o    = we_i[winner];
                master_wdata_o = wdata_i[winner];
                master_be_o    = be_i[winner];
                gnt_o[winner]  = master_gnt_i;
                if (master_gnt_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                r_valid_o[winner] = master_r_valid_i;
                if (master_r_valid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign r_rdata_o = master_r_rdata_i;

endmodule
